// File: rtl/dma_frame_pkg.sv
// Shared constants, word layouts and FSM encoding for the DMA frame transmitter.
package dma_frame_pkg;

  localparam logic [7:0] TRL_MAGIC = 8'hED;
  localparam logic [7:0] HDR_MAGIC = 8'hBE;

  localparam int MAGIC_LSB     = 56;
  localparam int TRL_TRUNC_BIT = 48;
  localparam int FRAME_LSB     = 32;
  localparam int WCNT_LSB      = 0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_HDR     = 2'd1;
  localparam state_t ST_DATA    = 2'd2;
  localparam state_t ST_TRAILER = 2'd3;

  function automatic logic [63:0] make_trailer(input logic trunc, input logic [15:0] frame,
                                               input logic [15:0] wcnt);
    logic [63:0] w;
    w = '0;
    w[MAGIC_LSB +: 8]  = TRL_MAGIC;
    w[TRL_TRUNC_BIT]   = trunc;
    w[FRAME_LSB +: 16] = frame;
    w[WCNT_LSB +: 16]  = wcnt;
    return w;
  endfunction

  function automatic logic [63:0] make_header(input logic [15:0] frame);
    logic [63:0] w;
    w = '0;
    w[MAGIC_LSB +: 8]  = HDR_MAGIC;
    w[FRAME_LSB +: 16] = frame;
    return w;
  endfunction

endpackage

// File: rtl/dma_tx_fifo.sv
// Synchronous FIFO, 2^AW entries of W bits; the head entry is read straight from
// the storage flops, so a write becomes visible one cycle later at the earliest.
module dma_tx_fifo #(
  parameter int AW = 4,
  parameter int W  = 66
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          do_wr, do_rd;

  assign do_wr = wr_en && !full_q;
  assign do_rd = rd_en && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_wr && !do_rd) cnt_d = cnt_q + CNT_ONE;
    else if (!do_wr && do_rd) cnt_d = cnt_q - CNT_ONE;
    full_d  = (cnt_d == CNT_FULL);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // The head slot is never rewritten while occupied, which keeps rd_data stable under stall.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/dma_frame_tx.sv
// Re-frames DMA readouts as AXI-Stream packets: [header,] data words, trailer.
// Define DMA_FRAME_HEADER_EN to prepend a header word to every packet.
module dma_frame_tx
  import dma_frame_pkg::*;
#(
  parameter int FIFO_AW   = 4,
  parameter int MAX_WORDS = 2048
) (
  input  logic        dma_clk,
  input  logic        reset_n,
  input  logic [63:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [63:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        m_sof,
  output logic [15:0] frames_sent,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  // Valid/ready: a beat happens on a rising edge where valid and ready are both high;
  // a source holds data and valid until that beat, and ready never depends on valid.
  state_t      state_q, state_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        trunc_q, trunc_d;
  logic [15:0] frames_sent_q, frames_sent_d;
  logic        rdy_en_q;

  logic        fifo_wr, fifo_full, fifo_empty;
  logic [65:0] fifo_wdata, fifo_rdata;
  logic        accept_state, in_beat, out_last_beat;

`ifdef DMA_FRAME_HEADER_EN
  assign accept_state = (state_q == ST_DATA);
`else
  assign accept_state = (state_q == ST_IDLE) || (state_q == ST_DATA);
`endif

  // rdy_en_q keeps s_ready low while reset is asserted.
  assign s_ready = rdy_en_q && !fifo_full && accept_state;
  assign in_beat = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    word_cnt_d  = word_cnt_q;
    trunc_d     = trunc_q;
    fifo_wr     = 1'b0;
    fifo_wdata  = '0;
    case (state_q)
      ST_IDLE: begin
`ifdef DMA_FRAME_HEADER_EN
        if (rdy_en_q && s_valid) state_d = ST_HDR;
`else
        if (in_beat) begin
          fifo_wr    = 1'b1;
          fifo_wdata = {1'b0, 1'b1, s_data};
          word_cnt_d = 16'd1;
          state_d    = s_last ? ST_TRAILER : ST_DATA;
        end
`endif
      end
      ST_HDR: begin
`ifdef DMA_FRAME_HEADER_EN
        if (!fifo_full) begin
          fifo_wr    = 1'b1;
          fifo_wdata = {1'b0, 1'b1, make_header(frame_cnt_q)};
          state_d    = ST_DATA;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DATA: begin
        if (in_beat) begin
          if (word_cnt_q < MAX_W) begin
            fifo_wr    = 1'b1;
            fifo_wdata = {1'b0, 1'b0, s_data};
            word_cnt_d = word_cnt_q + 16'd1;
          end else begin
            trunc_d = 1'b1;
          end
          if (s_last) state_d = ST_TRAILER;
        end
      end
      default: begin
        if (!fifo_full) begin
          fifo_wr     = 1'b1;
          fifo_wdata  = {1'b1, 1'b0, make_trailer(trunc_q, frame_cnt_q, word_cnt_q)};
          frame_cnt_d = frame_cnt_q + 16'd1;
          word_cnt_d  = '0;
          trunc_d     = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  assign out_last_beat = m_valid && m_ready && m_last;
  assign frames_sent_d = frames_sent_q + {15'd0, out_last_beat};

  always_ff @(posedge dma_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      frame_cnt_q   <= '0;
      word_cnt_q    <= '0;
      trunc_q       <= 1'b0;
      frames_sent_q <= '0;
      rdy_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      word_cnt_q    <= word_cnt_d;
      trunc_q       <= trunc_d;
      frames_sent_q <= frames_sent_d;
      rdy_en_q      <= 1'b1;
    end
  end

  dma_tx_fifo #(.AW(FIFO_AW), .W(66)) u_fifo (
    .clk     (dma_clk),
    .rst_n   (reset_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (m_ready),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid     = !fifo_empty;
  assign m_data      = fifo_rdata[63:0];
  assign m_sof       = fifo_rdata[64];
  assign m_last      = fifo_rdata[65];
  assign frames_sent = frames_sent_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dma_frame_tx.sv
// Scoreboard bench for dma_frame_tx: frame-level reference model feeds an expected
// queue; an output monitor pops and compares on every output beat.
module tb_dma_frame_tx;

  localparam int MAXW  = 20;
  localparam int DEPTH = 16;
`ifdef DMA_FRAME_HEADER_EN
  localparam int HDR_ON = 1;
`else
  localparam int HDR_ON = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic [63:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [63:0] m_data;
  logic        m_valid, m_ready, m_last, m_sof;
  logic [15:0] frames_sent;
  logic        busy;
  logic [1:0]  dbg_state;

  dma_frame_tx #(.FIFO_AW(4), .MAX_WORDS(MAXW)) dut (
    .dma_clk     (clk),
    .reset_n     (reset_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .m_sof       (m_sof),
    .frames_sent (frames_sent),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [65:0] exp_q[$];
  int          exp_frames = 0;
  int          model_frame = 0;
  int          in_beats = 0;
  int          late_waits = 0;
  int          mode = 1;
  logic [63:0] fdata[32];
  bit          drv_done;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // m_ready: 0 = random, 1 = always ready, 2 = stalled
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) m_ready = 1'b1;
      else if (mode == 2) m_ready = 1'b0;
      else m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // reference model: one frame of n input words -> expected packet
  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) fdata[i] = {$urandom, $urandom};
  endtask

  task automatic push_expected(input int n);
    int          fwd;
    logic        tr;
    logic [15:0] fc;
    fwd = (n > MAXW) ? MAXW : n;
    tr  = (n > MAXW);
    fc  = model_frame[15:0];
    if (HDR_ON != 0) exp_q.push_back({1'b0, 1'b1, 8'hBE, 8'h00, fc, 32'h0});
    for (int i = 0; i < fwd; i++)
      exp_q.push_back({1'b0, (HDR_ON == 0 && i == 0), fdata[i]});
    exp_q.push_back({1'b1, 1'b0, 8'hED, 7'h0, tr, fc, 16'h0, fwd[15:0]});
    model_frame = (model_frame + 1) % 65536;
  endtask

  // driver: called at a negedge; sends nsend of n words, last on word n-1
  task automatic drive_words(input int n, input int nsend, input int gap_pct);
    int w;
    for (int i = 0; i < nsend; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = fdata[i];
      s_last  = (i == n - 1);
      w = 0;
      while (!s_ready && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 2000) begin
        fail_now("input_handshake");
        i = nsend;
      end else begin
        if (i >= MAXW) late_waits += w;
        in_beats++;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) fail_now("drain");
    repeat (2) @(negedge clk);
    chk("frames_sent", frames_sent, exp_frames);
    chk("busy_idle", busy, 0);
  endtask

  // monitor / scoreboard
  initial begin
    logic [65:0] cur, prev_word, e;
    bit          prev_stall;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        exp_frames = 0;
        prev_stall = 1'b0;
      end else begin
        cur = {m_last, m_sof, m_data};
        if (prev_stall) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_word", cur, prev_word);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_unexpected: got %h expected nothing", cur);
          end else begin
            e = exp_q.pop_front();
            chk("out_word", cur, e);
            if (e[65]) exp_frames++;
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_word  = cur;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last_sof"}, {m_last, m_sof}, 0);
    chk({tag, "_frames_sent"}, frames_sent, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int w;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #3 check_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("s_ready_after_reset", s_ready, 1);

    // basic 3-word frame
    mode = 1;
    fdata[0] = 64'h1; fdata[1] = 64'h2; fdata[2] = 64'h3;
    push_expected(3);
    drive_words(3, 3, 0);
    drain();

    // backpressure: 20 words into a stalled output
    mode = 2;
    fill_random(20);
    push_expected(20);
    in_beats = 0;
    drv_done = 1'b0;
    fork
      begin
        drive_words(20, 20, 0);
        drv_done = 1'b1;
      end
    join_none
    repeat (40) @(negedge clk);
    chk("bp_accepted", in_beats, DEPTH - HDR_ON);
    chk("bp_s_ready_low", s_ready, 0);
    mode = 1;
    w = 0;
    while (!drv_done && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!drv_done) fail_now("bp_driver");
    drain();

    // truncation: 23 beats with 20 forwarded
    mode = 1;
    late_waits = 0;
    fill_random(23);
    push_expected(23);
    drive_words(23, 23, 0);
    chk("trunc_drop_ready", late_waits, 0);
    drain();

    // back-to-back 1-word and 2-word frames
    fill_random(1);
    push_expected(1);
    drive_words(1, 1, 0);
    fill_random(2);
    push_expected(2);
    drive_words(2, 2, 0);
    drain();

    // reset in the middle of a frame
    mode = 2;
    fill_random(5);
    drive_words(5, 2, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    model_frame = 0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mode = 1;
    fill_random(1);
    push_expected(1);
    drive_words(1, 1, 0);
    drain();

    // randomized frames with input gaps and output stalls
    mode = 0;
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(1, 26);
      fill_random(n);
      push_expected(n);
      drive_words(n, n, 30);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
